// File: rtl/key_debouncer_bank.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer_bank
// Description : Multi-channel push-button conditioner. Each of N_KEYS raw,
//               asynchronous key inputs is synchronised (two flops),
//               debounced, and turned into a clean level plus one-cycle
//               press, release and long-press strobes. With
//               KEY_DEBOUNCER_BANK_REPEAT_EN defined, a held key also
//               produces periodic auto-repeat strobes after the long press.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1       clock
//   reset_n        in   1       asynchronous active-low reset
//   key_in         in   N_KEYS  raw active-high key levels (asynchronous)
//   key_state      out  N_KEYS  debounced level
//   press_pulse    out  N_KEYS  one-cycle strobe on accepted 0->1
//   release_pulse  out  N_KEYS  one-cycle strobe on accepted 1->0
//   long_pulse     out  N_KEYS  one-cycle strobe when a press reaches LONG_CYCLES
//   repeat_pulse   out  N_KEYS  auto-repeat strobe (0 when repeat is compiled out)
// Configuration macro
//   KEY_DEBOUNCER_BANK_REPEAT_EN  builds the per-channel auto-repeat counter
// ============================================================================
module key_debouncer_bank #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  // Counters only ever hold 0 .. LIMIT-1, so $clog2(LIMIT) bits suffice.
  localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);

`ifdef KEY_DEBOUNCER_BANK_REPEAT_EN
  localparam int c_RP_W = $clog2(REPEAT_CYCLES);
  localparam logic [c_RP_W-1:0] c_RP_LAST = c_RP_W'(REPEAT_CYCLES - 1);
`else
  // Repeat period is meaningless without the repeat counter.
  localparam int c_unused_repeat_cycles = REPEAT_CYCLES;
`endif

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } hold_state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan

    logic                r_sync1;
    logic                r_sync2;
    logic                r_key_state;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_next;
    hold_state_t         r_state;
    hold_state_t         w_state_next;
    logic                w_long_fire;
    logic                w_accept;
    logic                w_accept_press;
    logic                w_accept_release;

    // A new level is accepted on the edge where it has already been seen
    // for DEBOUNCE_CYCLES-1 consecutive cycles, i.e. it persists for the
    // full DEBOUNCE_CYCLES window.
    assign w_accept         = (r_sync2 != r_key_state) && (r_db_cnt == c_DB_LAST);
    assign w_accept_press   = w_accept &  r_sync2;
    assign w_accept_release = w_accept & ~r_sync2;

    // Synchroniser, debounce counter and press/release strobes.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync1     <= 1'b0;
        r_sync2     <= 1'b0;
        r_key_state <= 1'b0;
        r_db_cnt    <= '0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
      end else begin
        r_sync1 <= key_in[i];
        r_sync2 <= r_sync1;
        if (r_sync2 != r_key_state) begin
          if (r_db_cnt == c_DB_LAST) begin
            r_key_state <= r_sync2;
            r_db_cnt    <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
          end
        end else begin
          // Bounce back to the current level restarts qualification.
          r_db_cnt <= '0;
        end
        r_press   <= w_accept_press;
        r_release <= w_accept_release;
      end
    end

    // Hold FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state    <= ST_RELEASED;
        r_hold_cnt <= '0;
        r_long     <= 1'b0;
      end else begin
        r_state    <= w_state_next;
        r_hold_cnt <= w_hold_next;
        r_long     <= w_long_fire;
      end
    end

    // Hold FSM: next state. Release wins over everything; the hold counter
    // stops at LONG_CYCLES-1 by leaving PRESSED, so it can never wrap.
    always_comb begin
      w_state_next = r_state;
      w_hold_next  = r_hold_cnt;
      w_long_fire  = 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (w_accept_press) begin
            w_state_next = ST_PRESSED;
            w_hold_next  = '0;
          end
        end
        ST_PRESSED: begin
          if (w_accept_release) begin
            w_state_next = ST_RELEASED;
            w_hold_next  = '0;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            w_state_next = ST_LONG;
            w_long_fire  = 1'b1;
          end else begin
            w_hold_next = r_hold_cnt + c_HOLD_W'(1);
          end
        end
        ST_LONG: begin
          if (w_accept_release) begin
            w_state_next = ST_RELEASED;
            w_hold_next  = '0;
          end
        end
        default: begin
          w_state_next = ST_RELEASED;
          w_hold_next  = '0;
        end
      endcase
    end

`ifdef KEY_DEBOUNCER_BANK_REPEAT_EN
    logic [c_RP_W-1:0] r_rep_cnt;
    logic              r_repeat;

    // Counts only while in LONG; the LONG entry edge leaves it at 0, so the
    // first strobe lands REPEAT_CYCLES after long_pulse.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rep_cnt <= '0;
        r_repeat  <= 1'b0;
      end else if ((r_state == ST_LONG) && !w_accept_release) begin
        if (r_rep_cnt == c_RP_LAST) begin
          r_rep_cnt <= '0;
          r_repeat  <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + c_RP_W'(1);
          r_repeat  <= 1'b0;
        end
      end else begin
        r_rep_cnt <= '0;
        r_repeat  <= 1'b0;
      end
    end

    assign repeat_pulse[i] = r_repeat;
`else
    assign repeat_pulse[i] = 1'b0;
`endif

    assign key_state[i]     = r_key_state;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
    assign long_pulse[i]    = r_long;

  end

endmodule
`default_nettype wire
